// File: rtl/tcp_rx_verify_engine_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tcp_rx_verify_engine_if : RX metadata + data stream bundle for the checker |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface tcp_rx_verify_engine_if #(
    parameter int DATA_WIDTH = 512,
    parameter int SID_WIDTH  = 16
) ();
    logic                    s_meta_valid;
    logic                    s_meta_ready;
    logic [32+SID_WIDTH-1:0] s_meta_data;
    logic                    s_data_valid;
    logic                    s_data_ready;
    logic [DATA_WIDTH-1:0]   s_data_data;
    logic                    s_data_last;

    modport master (
        output s_meta_valid, s_meta_data, s_data_valid, s_data_data, s_data_last,
        input  s_meta_ready, s_data_ready
    );

    modport slave (
        input  s_meta_valid, s_meta_data, s_data_valid, s_data_data, s_data_last,
        output s_meta_ready, s_data_ready
    );
endinterface
`default_nettype wire

// File: rtl/tcp_rx_verify_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tcp_rx_verify_engine : TCP RX sink that checks per-session payload         |
// | sequences and segment lengths, and times a programmed op count.            |
// | Optional macro TCP_RX_FULL_LANE_CHECK_EN checks every 32-bit lane.         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tcp_rx_verify_engine #(
    parameter int DATA_WIDTH   = 512,
    parameter int NUM_SESSIONS = 4,
    parameter int SID_WIDTH    = 16
) (
    input  wire logic              clk,
    input  wire logic              rstn,
    tcp_rx_verify_engine_if.slave  s_if,
    input  wire logic [15:0][31:0] control_reg,
    output logic      [7:0][31:0]  status_reg
);
    localparam int BYTES      = DATA_WIDTH / 8;
    localparam int LOG2_BYTES = $clog2(BYTES);
    localparam int LANES      = DATA_WIDTH / 32;
    localparam int SIDX_W     = (NUM_SESSIONS > 1) ? $clog2(NUM_SESSIONS) : 1;

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_DATA = 1'b1} state_e;
    state_e state_q, state_d;

    logic [4:0][31:0]  ctrl_q;
    logic              clr_prev_q, alive_q;
    logic [31:0]       words_per_op_q;
    logic [4:0]        free_cnt_q;
    logic [31:0]       seq_q [NUM_SESSIONS];
    logic [SIDX_W-1:0] sidx_q;
    logic [31:0]       seg_words_q, beat_cnt_q;
    logic              th_run_q, th_armed_q;
    logic [31:0]       th_cnt_q, err_cnt_q, first_err_q, beats_q, ops_done_q, meta_cnt_q, len_err_q;

    logic              w_soft_clr, w_meta_rdy, w_data_rdy, w_meta_hs, w_beat_hs, w_mismatch, w_wrap;
    logic [31:0]       w_seq, w_exp, w_len, w_wpo_shift, w_seg_words;
    logic [32:0]       w_seg_ceil;
    logic [SIDX_W-1:0] w_meta_sidx;

    wire unused_bits = ^{control_reg[15:5], ctrl_q[0][31:1], s_if.s_meta_data, s_if.s_data_data};

    assign w_soft_clr  = ctrl_q[0][0] & ~clr_prev_q;
    assign w_meta_rdy  = alive_q & (state_q == ST_IDLE);
    assign w_data_rdy  = (state_q == ST_DATA) & ~ctrl_q[4][free_cnt_q];
    assign w_meta_hs   = w_meta_rdy & s_if.s_meta_valid & ~w_soft_clr;
    assign w_beat_hs   = w_data_rdy & s_if.s_data_valid & ~w_soft_clr;
    assign w_seq       = seq_q[sidx_q];
    assign w_exp       = w_seq + ctrl_q[3];
    assign w_wrap      = (w_seq == words_per_op_q);
    assign w_wpo_shift = ctrl_q[1] >> LOG2_BYTES;
    assign w_len       = s_if.s_meta_data[SID_WIDTH +: 32];
    assign w_meta_sidx = (NUM_SESSIONS == 1) ? '0 : s_if.s_meta_data[SIDX_W-1:0];
    // A zero-length segment still carries one beat.
    assign w_seg_ceil  = ({1'b0, w_len} + 33'(BYTES - 1)) >> LOG2_BYTES;
    assign w_seg_words = (w_seg_ceil == 33'd0) ? 32'd1 : w_seg_ceil[31:0];

`ifdef TCP_RX_FULL_LANE_CHECK_EN
    always_comb begin
        w_mismatch = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (s_if.s_data_data[32*i +: 32] != w_exp + 32'(i)) begin
                w_mismatch = 1'b1;
            end
        end
    end
`else
    assign w_mismatch = (s_if.s_data_data[31:0] != w_exp);
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (w_meta_hs) state_d = ST_DATA;
            ST_DATA: if (w_beat_hs && s_if.s_data_last) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (w_soft_clr) state_d = ST_IDLE;
        s_if.s_meta_ready = w_meta_rdy;
        s_if.s_data_ready = w_data_rdy;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ctrl_q         <= '0;
            clr_prev_q     <= 1'b0;
            alive_q        <= 1'b0;
            words_per_op_q <= '0;
            free_cnt_q     <= '0;
            for (int i = 0; i < NUM_SESSIONS; i++) seq_q[i] <= '0;
            sidx_q         <= '0;
            seg_words_q    <= '0;
            beat_cnt_q     <= '0;
            th_run_q       <= 1'b0;
            th_armed_q     <= 1'b0;
            th_cnt_q       <= '0;
            err_cnt_q      <= '0;
            first_err_q    <= '0;
            beats_q        <= '0;
            ops_done_q     <= '0;
            meta_cnt_q     <= '0;
            len_err_q      <= '0;
        end else begin
            ctrl_q         <= control_reg[4:0];
            clr_prev_q     <= ctrl_q[0][0];
            alive_q        <= 1'b1;
            free_cnt_q     <= free_cnt_q + 5'd1;
            words_per_op_q <= (w_wpo_shift == 32'd0) ? 32'd0 : w_wpo_shift - 32'd1;
            if (w_soft_clr) begin
                for (int i = 0; i < NUM_SESSIONS; i++) seq_q[i] <= '0;
                beat_cnt_q  <= '0;
                th_run_q    <= 1'b0;
                th_armed_q  <= 1'b0;
                th_cnt_q    <= '0;
                err_cnt_q   <= '0;
                first_err_q <= '0;
                beats_q     <= '0;
                ops_done_q  <= '0;
                meta_cnt_q  <= '0;
                len_err_q   <= '0;
            end else begin
                if (th_run_q) th_cnt_q <= th_cnt_q + 32'd1;
                if (th_run_q && (ctrl_q[2] != 32'd0) && (ops_done_q == ctrl_q[2])) th_run_q <= 1'b0;
                if (w_meta_hs) begin
                    sidx_q      <= w_meta_sidx;
                    seg_words_q <= w_seg_words;
                    beat_cnt_q  <= '0;
                    meta_cnt_q  <= meta_cnt_q + 32'd1;
                    // Timer starts once per measurement window.
                    if (!th_armed_q) begin
                        th_run_q   <= 1'b1;
                        th_armed_q <= 1'b1;
                    end
                end
                if (w_beat_hs) begin
                    beats_q        <= beats_q + 32'd1;
                    beat_cnt_q     <= beat_cnt_q + 32'd1;
                    seq_q[sidx_q]  <= w_wrap ? 32'd0 : w_seq + 32'd1;
                    if (w_wrap) ops_done_q <= ops_done_q + 32'd1;
                    if (w_mismatch) begin
                        if (err_cnt_q != 32'hFFFF_FFFF) err_cnt_q <= err_cnt_q + 32'd1;
                        if (err_cnt_q == 32'd0) first_err_q <= {8'(sidx_q), w_seq[23:0]};
                    end
                    if (s_if.s_data_last && (beat_cnt_q + 32'd1 != seg_words_q)) begin
                        len_err_q <= len_err_q + 32'd1;
                    end
                end
            end
        end
    end

    always_comb begin
        status_reg    = '0;
        status_reg[0] = th_cnt_q;
        status_reg[1] = err_cnt_q;
        status_reg[2] = first_err_q;
        status_reg[3] = beats_q;
        status_reg[4] = ops_done_q;
        status_reg[5] = meta_cnt_q;
        status_reg[6] = len_err_q;
        status_reg[7] = {30'd0, state_q == ST_DATA, th_run_q};
    end
endmodule
`default_nettype wire

// File: tb/tb_tcp_rx_verify_engine.sv
`default_nettype none
// Bench for tcp_rx_verify_engine: directed scenarios, a length-check vector
// table and randomized segments scored against a per-session beat-count model.
module tb_tcp_rx_verify_engine;
    localparam int DW = 512;
    localparam int NS = 4;
    localparam int SW = 16;
    localparam int BYTES = DW / 8;
    localparam int LANES = DW / 32;

    logic clk = 1'b0;
    logic rstn;
    logic [15:0][31:0] ctrl;
    logic [7:0][31:0]  st;

    tcp_rx_verify_engine_if #(.DATA_WIDTH(DW), .SID_WIDTH(SW)) dif ();

    tcp_rx_verify_engine #(.DATA_WIDTH(DW), .NUM_SESSIONS(NS), .SID_WIDTH(SW)) dut (
        .clk(clk), .rstn(rstn), .s_if(dif), .control_reg(ctrl), .status_reg(st)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: beats accepted per session; sequence = count mod period.
    int unsigned P;
    logic [31:0] m_off;
    int unsigned m_cnt [NS];
    int unsigned m_beats, m_meta, m_err, m_len_err;
    logic [31:0] m_first;

    typedef struct {
        int          sid;
        int unsigned len;
        int          nbeats;
        logic [31:0] exp_len_err;
        logic [31:0] exp_st7;
    } vec_t;
    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic finish_sim();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    task automatic model_reset();
        for (int s = 0; s < NS; s++) m_cnt[s] = 0;
        m_beats = 0; m_meta = 0; m_err = 0; m_len_err = 0; m_first = '0;
    endtask

    function automatic logic [31:0] m_ops();
        int unsigned t = 0;
        for (int s = 0; s < NS; s++) t += m_cnt[s] / P;
        return t;
    endfunction

    task automatic set_cfg(input int unsigned len, input logic [31:0] ops,
                           input logic [31:0] off, input logic [31:0] mask);
        @(negedge clk);
        ctrl[1] = len; ctrl[2] = ops; ctrl[3] = off; ctrl[4] = mask;
        P = (len / BYTES == 0) ? 1 : len / BYTES;
        m_off = off;
        repeat (3) @(negedge clk);
    endtask

    task automatic soft_clear();
        @(negedge clk);
        ctrl[0][0] = 1'b1;
        repeat (3) @(negedge clk);
        ctrl[0][0] = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
    endtask

    task automatic idle_bus();
        @(negedge clk);
        dif.s_meta_valid = 1'b0;
        dif.s_data_valid = 1'b0;
        dif.s_data_last  = 1'b0;
    endtask

    task automatic wait_ready(input bit is_meta);
        int n = 0;
        while ((is_meta ? dif.s_meta_ready : dif.s_data_ready) !== 1'b1) begin
            if (n == 2000) begin
                checks++; errors++;
                $display("FAIL handshake_timeout: ready=%b after %0d cycles, expected 1", is_meta ? dif.s_meta_ready : dif.s_data_ready, n);
                finish_sim();
            end
            @(negedge clk);
            n++;
        end
    endtask

    task automatic send_meta(input int sid, input int unsigned len);
        @(negedge clk);
        dif.s_data_valid = 1'b0;
        dif.s_data_last  = 1'b0;
        dif.s_meta_data  = {len, 16'(sid)};
        dif.s_meta_valid = 1'b1;
        wait_ready(1'b1);
        @(posedge clk);
        m_meta++;
    endtask

    task automatic put_beat(input int sid, input bit last, input bit corrupt);
        logic [DW-1:0] d;
        logic [31:0] base;
        @(negedge clk);
        dif.s_meta_valid = 1'b0;
        base = m_off + 32'(m_cnt[sid] % P);
        for (int i = 0; i < LANES; i++) d[32*i +: 32] = base + 32'(i);
        if (corrupt) d[31:0] = d[31:0] ^ 32'hDEAD_0001;
        dif.s_data_data  = d;
        dif.s_data_last  = last;
        dif.s_data_valid = 1'b1;
        wait_ready(1'b0);
        @(posedge clk);
        if (corrupt) begin
            if (m_err == 0) m_first = {8'(sid), 24'(m_cnt[sid] % P)};
            m_err++;
        end
        m_cnt[sid]++;
        m_beats++;
    endtask

    task automatic send_seg(input int sid, input int unsigned len, input int nbeats, input logic [63:0] cmask);
        int unsigned need;
        send_meta(sid, len);
        for (int b = 0; b < nbeats; b++) put_beat(sid, b == nbeats - 1, (b < 64) ? cmask[b] : 1'b0);
        need = (len == 0) ? 1 : (len + BYTES - 1) / BYTES;
        if (need != nbeats) m_len_err++;
    endtask

    task automatic check_model(input string tag);
        repeat (3) @(negedge clk);
        check({tag, "_errcnt"}, st[1], m_err);
        if (m_err != 0) check({tag, "_first_err"}, st[2], m_first);
        check({tag, "_beats"}, st[3], m_beats);
        check({tag, "_ops_done"}, st[4], m_ops());
        check({tag, "_meta_cnt"}, st[5], m_meta);
        check({tag, "_len_err"}, st[6], m_len_err);
    endtask

    initial begin
        int ones, toggles;
        logic prev;
        vecs[0] = '{0, 640, 10, 0, 1};
        vecs[1] = '{1, 640, 8, 1, 1};
        vecs[2] = '{2, 0, 1, 1, 1};
        vecs[3] = '{3, 0, 2, 2, 1};
        vecs[4] = '{0, 65, 2, 2, 1};
        vecs[5] = '{1, 64, 2, 3, 1};
        vecs[6] = '{2, 1, 1, 3, 1};
        vecs[7] = '{3, 4096, 64, 3, 1};

        ctrl = '0;
        rstn = 1'b0;
        dif.s_meta_valid = 1'b0; dif.s_meta_data = '0;
        dif.s_data_valid = 1'b0; dif.s_data_data = '0; dif.s_data_last = 1'b0;
        P = 1; m_off = '0;
        model_reset();

        #1;
        check("reset_meta_ready", {31'd0, dif.s_meta_ready}, 32'd0);
        check("reset_data_ready", {31'd0, dif.s_data_ready}, 32'd0);
        for (int w = 0; w < 8; w++) check($sformatf("reset_status%0d", w), st[w], 32'd0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_meta_ready", {31'd0, dif.s_meta_ready}, 32'd1);
        check("idle_data_ready", {31'd0, dif.s_data_ready}, 32'd0);

        // Four full ops on session 0: timer stops once the target is met.
        set_cfg(4096, 4, 32'h100, 32'h0);
        for (int k = 0; k < 4; k++) send_seg(0, 4096, 64, '0);
        idle_bus();
        check_model("ops4");
        check("ops4_ops_const", st[4], 32'd4);
        check("ops4_status7", st[7], 32'd0);
        checks++;
        if (st[0] < 32'd256) begin
            errors++;
            $display("FAIL ops4_th_cnt: got %0d, expected >= 256", st[0]);
        end

        // Interleaved sessions 1 and 2 keep independent sequences.
        soft_clear();
        for (int k = 0; k < 8; k++) send_seg(1 + (k % 2), 2048, 32, '0);
        idle_bus();
        check_model("interleave");

        // Lane-0 corruption on beats 5 and 9 of session 3.
        soft_clear();
        send_seg(3, 4096, 64, 64'h0000_0000_0000_0220);
        idle_bus();
        check_model("corrupt");
        check("corrupt_errcnt_const", st[1], 32'd2);
        check("corrupt_first_const", st[2], 32'h0300_0005);

        // Segment length table.
        soft_clear();
        for (int v = 0; v < 8; v++) begin
            send_seg(vecs[v].sid, vecs[v].len, vecs[v].nbeats, '0);
            idle_bus();
            repeat (2) @(negedge clk);
            check($sformatf("vec%0d_len_err", v), st[6], vecs[v].exp_len_err);
            check($sformatf("vec%0d_status7", v), st[7], vecs[v].exp_st7);
            check($sformatf("vec%0d_meta_ready", v), {31'd0, dif.s_meta_ready}, 32'd1);
        end
        check_model("vectors");

        // Alternating throttle mask.
        set_cfg(4096, 4, 32'h0, 32'h5555_5555);
        soft_clear();
        send_meta(0, 1280);
        idle_bus();
        prev = dif.s_data_ready;
        ones = 0; toggles = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (dif.s_data_ready === 1'b1) ones++;
            if (dif.s_data_ready !== prev) toggles++;
            prev = dif.s_data_ready;
        end
        check("throttle_ones", 32'(ones), 32'd8);
        check("throttle_toggles", 32'(toggles), 32'd16);
        for (int b = 0; b < 20; b++) put_beat(0, b == 19, 1'b0);
        idle_bus();
        check_model("throttle");

        // Soft-clear in the middle of a segment.
        send_meta(1, 1280);
        for (int b = 0; b < 5; b++) put_beat(1, 1'b0, 1'b0);
        idle_bus();
        soft_clear();
        for (int w = 0; w < 8; w++) check($sformatf("softclr_status%0d", w), st[w], 32'd0);
        check("softclr_meta_ready", {31'd0, dif.s_meta_ready}, 32'd1);

        // Randomized segments against the model.
        for (int r = 0; r < 2; r++) begin
            int unsigned lens [5] = '{32, 64, 256, 640, 4096};
            logic [31:0] mask;
            mask = $urandom() & ~(32'd1 << $urandom_range(31, 0));
            set_cfg(lens[$urandom_range(4, 0)], 32'd0, $urandom(), mask);
            soft_clear();
            for (int k = 0; k < 25; k++) begin
                int unsigned len;
                int nb;
                logic [63:0] cm;
                len = $urandom_range(1023, 0);
                nb = (len == 0) ? 1 : int'((len + BYTES - 1) / BYTES);
                if ($urandom_range(3, 0) == 0) nb = $urandom_range(16, 1);
                cm = {$urandom(), $urandom()} & {$urandom(), $urandom()} &
                     {$urandom(), $urandom()} & {$urandom(), $urandom()};
                send_seg($urandom_range(NS - 1, 0), len, nb, cm);
            end
            idle_bus();
            check_model($sformatf("rand%0d", r));
            check($sformatf("rand%0d_status7", r), st[7], 32'd1);
        end

        // Asynchronous reset while a segment is in flight.
        set_cfg(4096, 4, 32'h0, 32'h0);
        soft_clear();
        send_meta(0, 4096);
        for (int b = 0; b < 10; b++) put_beat(0, 1'b0, 1'b0);
        @(posedge clk);
        #3 rstn = 1'b0;
        #1;
        check("arst_meta_ready", {31'd0, dif.s_meta_ready}, 32'd0);
        check("arst_data_ready", {31'd0, dif.s_data_ready}, 32'd0);
        for (int w = 0; w < 8; w++) check($sformatf("arst_status%0d", w), st[w], 32'd0);
        dif.s_data_valid = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        finish_sim();
    end
endmodule
`default_nettype wire
